fp_sqrt_issuer: RTL

- Client-side front end for the floating-point square-root engine: the initiator of its start/ready handshake.
- Accepts a packed IEEE-754 operand (single or double) on a valid/ready input port, decodes it into the engine's mantissa/exponent/sign/type/flags fields, and pulses start.
- Waits for the engine's ready, re-packs the result into IEEE-754 and holds it on a valid/ready output port until consumed.
- A watchdog flags engines that never answer.

---
 rtl/fp_sqrt_issuer_if.sv | 55 +++++
 rtl/fp_sqrt_issuer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_issuer_if.sv
// ----------------------------------------------------------------------------
// fp_sqrt_issuer_if
// Bundles the three ports of the square-root issuer:
//   op_*       : packed IEEE-754 operand in (valid/ready)
//   sqrt_*     : decoded operand and start pulse to the engine
//   sqrt_out_* : engine result and its level-type ready
//   res_*      : packed result out (valid/ready) with class flags / timeout
// master : the issuer itself
// slave  : everything around it (operand source, engine, result consumer)
// ----------------------------------------------------------------------------
interface fp_sqrt_issuer_if #(
    parameter int M_SIZE   = 53,
    parameter int EXP_SIZE = 11
);
    logic                op_valid;
    logic                op_ready;
    logic [63:0]         op_data;
    logic                op_type;

    logic [M_SIZE-1:0]   sqrt_mantisa;
    logic [EXP_SIZE-1:0] sqrt_exp;
    logic                sqrt_sign;
    logic                sqrt_type;
    logic [2:0]          sqrt_flags;
    logic                sqrt_start;

    logic [M_SIZE-1:0]   sqrt_out_mantisa;
    logic [EXP_SIZE-1:0] sqrt_out_exp;
    logic                sqrt_out_sign;
    logic                sqrt_out_ready;

    logic                res_valid;
    logic                res_ready;
    logic [63:0]         res_data;
    logic [2:0]          res_flags;
    logic                res_timeout;

    modport master (
        input  op_valid, op_data, op_type,
        output op_ready,
        output sqrt_mantisa, sqrt_exp, sqrt_sign, sqrt_type, sqrt_flags, sqrt_start,
        input  sqrt_out_mantisa, sqrt_out_exp, sqrt_out_sign, sqrt_out_ready,
        output res_valid, res_data, res_flags, res_timeout,
        input  res_ready
    );

    modport slave (
        output op_valid, op_data, op_type,
        input  op_ready,
        input  sqrt_mantisa, sqrt_exp, sqrt_sign, sqrt_type, sqrt_flags, sqrt_start,
        output sqrt_out_mantisa, sqrt_out_exp, sqrt_out_sign, sqrt_out_ready,
        input  res_valid, res_data, res_flags, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/fp_sqrt_issuer.sv
// ----------------------------------------------------------------------------
// fp_sqrt_issuer
// Client-side front end of the floating-point square-root engine. Takes a
// packed single/double operand, decodes it into the engine fields plus a
// class code, pulses sqrt_start, waits for a fresh rising edge of the
// engine's ready, re-packs the result and holds it until consumed. A
// watchdog aborts the wait if the engine never answers.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fp_sqrt_issuer_if.master (operand, engine and result ports)
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | op_ready high, waiting for an operand
//   S_ISSUE | decoded operand on sqrt_*, sqrt_start pulsed, counter cleared
//   S_WAIT  | waiting for a rising edge of sqrt_out_ready or the watchdog
//   S_DONE  | result (or timeout) held on res_* until res_ready
// ----------------------------------------------------------------------------
module fp_sqrt_issuer #(
    parameter int M_SIZE         = 53,
    parameter int EXP_SIZE       = 11,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    fp_sqrt_issuer_if.master  bus
);
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] FL_DENORM = 3'b000;
    localparam logic [2:0] FL_ZERO   = 3'b001;
    localparam logic [2:0] FL_INF    = 3'b010;
    localparam logic [2:0] FL_NAN    = 3'b011;
    localparam logic [2:0] FL_NORMAL = 3'b100;
    localparam logic [2:0] FL_SIGN   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state, state_next;

    logic [M_SIZE-1:0]   sqrt_mantisa_q;
    logic [EXP_SIZE-1:0] sqrt_exp_q;
    logic                sqrt_sign_q;
    logic                sqrt_type_q;
    logic [2:0]          sqrt_flags_q;

    logic                res_valid_q;
    logic [63:0]         res_data_q;
    logic [2:0]          res_flags_q;
    logic                res_timeout_q;

    logic [CNT_W-1:0]    count;
    logic                ready_q;

    logic                load_op, capture, abort, res_pop;
    logic                op_ready_c, start_c;

    logic                dec_sign, dec_e_zero, dec_e_ones, dec_f_zero;
    logic [M_SIZE-1:0]   dec_mant;
    logic [EXP_SIZE-1:0] dec_exp;
    logic [2:0]          dec_flags;
    logic [63:0]         pack_data;

    // Engine hidden bit is not part of either IEEE encoding.
    logic                unused_hidden;
    assign unused_hidden = bus.sqrt_out_mantisa[M_SIZE-1];

    // ready_q follows the engine every cycle so a level left high from a
    // previous operation already looks "old" on the first WAIT cycle.
    logic ready_edge;
    assign ready_edge = bus.sqrt_out_ready & ~ready_q;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.op_type) begin
            dec_sign   = bus.op_data[63];
            dec_e_zero = (bus.op_data[62:52] == '0);
            dec_e_ones = &bus.op_data[62:52];
            dec_f_zero = (bus.op_data[51:0] == '0);
            dec_exp    = EXP_SIZE'(bus.op_data[62:52]);
            dec_mant   = M_SIZE'({~dec_e_zero, bus.op_data[51:0]});
        end else begin
            dec_sign   = bus.op_data[31];
            dec_e_zero = (bus.op_data[30:23] == '0);
            dec_e_ones = &bus.op_data[30:23];
            dec_f_zero = (bus.op_data[22:0] == '0);
            dec_exp    = EXP_SIZE'(bus.op_data[30:23]);
            dec_mant   = M_SIZE'({~dec_e_zero, bus.op_data[22:0]});
        end

        // Priority order matters: NaN and zero win over the sign check so
        // that -0 and negative NaNs are not reported as sign errors.
        if (dec_e_ones && !dec_f_zero)      dec_flags = FL_NAN;
        else if (dec_e_zero && dec_f_zero)  dec_flags = FL_ZERO;
        else if (dec_sign)                  dec_flags = FL_SIGN;
        else if (dec_e_ones)                dec_flags = FL_INF;
        else if (dec_e_zero)                dec_flags = FL_DENORM;
        else                                dec_flags = FL_NORMAL;
    end

    // ------------------------------------------------------------------
    // Result pack, format chosen by the latched operand type
    // ------------------------------------------------------------------
    always_comb begin
        if (sqrt_type_q) begin
            pack_data = {bus.sqrt_out_sign, bus.sqrt_out_exp[10:0],
                         bus.sqrt_out_mantisa[51:0]};
        end else begin
            pack_data = {32'b0, bus.sqrt_out_sign, bus.sqrt_out_exp[7:0],
                         bus.sqrt_out_mantisa[22:0]};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        res_pop    = 1'b0;
        op_ready_c = 1'b0;
        start_c    = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready_c = 1'b1;
                if (bus.op_valid) begin
                    load_op    = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_c    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (ready_edge) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end else if (count == CNT_MAX) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_pop    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sqrt_mantisa_q <= '0;
            sqrt_exp_q     <= '0;
            sqrt_sign_q    <= 1'b0;
            sqrt_type_q    <= 1'b0;
            sqrt_flags_q   <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_flags_q    <= '0;
            res_timeout_q  <= 1'b0;
            count          <= '0;
            ready_q        <= 1'b0;
        end else begin
            ready_q <= bus.sqrt_out_ready;

            if (load_op) begin
                sqrt_mantisa_q <= dec_mant;
                sqrt_exp_q     <= dec_exp;
                sqrt_sign_q    <= dec_sign;
                sqrt_type_q    <= bus.op_type;
                sqrt_flags_q   <= dec_flags;
            end

            if (state == S_ISSUE)     count <= '0;
            else if (state == S_WAIT) count <= count + 1'b1;

            if (capture) begin
                res_valid_q   <= 1'b1;
                res_data_q    <= pack_data;
                res_flags_q   <= sqrt_flags_q;
                res_timeout_q <= 1'b0;
            end else if (abort) begin
                res_valid_q   <= 1'b1;
                res_data_q    <= '0;
                res_flags_q   <= sqrt_flags_q;
                res_timeout_q <= 1'b1;
            end else if (res_pop) begin
                res_valid_q   <= 1'b0;
                res_timeout_q <= 1'b0;
            end
        end
    end

    assign bus.op_ready     = op_ready_c;
    assign bus.sqrt_start   = start_c;
    assign bus.sqrt_mantisa = sqrt_mantisa_q;
    assign bus.sqrt_exp     = sqrt_exp_q;
    assign bus.sqrt_sign    = sqrt_sign_q;
    assign bus.sqrt_type    = sqrt_type_q;
    assign bus.sqrt_flags   = sqrt_flags_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_flags    = res_flags_q;
    assign bus.res_timeout  = res_timeout_q;
endmodule
